// File: rtl/pio_accel_seq_pkg.sv
// Shared opcodes, FSM states and pi_export field positions for the PIO accelerator sequencer.
package pio_accel_seq_pkg;

   localparam int unsigned OP_W = 3;

   localparam logic [OP_W-1:0] OP_NOP   = 3'd0;
   localparam logic [OP_W-1:0] OP_PUSH  = 3'd1;
   localparam logic [OP_W-1:0] OP_START = 3'd2;
   localparam logic [OP_W-1:0] OP_POP   = 3'd3;
   localparam logic [OP_W-1:0] OP_CLR   = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_ACK  = 2'd2
   } state_e;

   // po_export command fields
   localparam int unsigned PO_REQ_BIT = 31;
   localparam int unsigned PO_OP_LSB  = 28;

   // pi_export status fields
   localparam int unsigned PI_ACK_BIT   = 31;
   localparam int unsigned PI_BUSY_BIT  = 30;
   localparam int unsigned PI_ERR_BIT   = 29;
   localparam int unsigned PI_EMPTY_BIT = 28;
   localparam int unsigned PI_LVL_LSB   = 24;
   localparam int unsigned PI_LVL_W     = 4;
   localparam int unsigned PI_LVL_MAX   = 15;
   localparam int unsigned PI_RES_W     = 24;

   // Clamp a FIFO level into the 4-bit status field.
   function automatic logic [PI_LVL_W-1:0] sat_level(input logic [31:0] lvl);
      return (lvl > 32'(PI_LVL_MAX)) ? PI_LVL_W'(PI_LVL_MAX) : lvl[PI_LVL_W-1:0];
   endfunction

endpackage

// File: rtl/pio_result_fifo.sv
// Synchronous result FIFO with flush; overflowing pushes are dropped and flagged.
module pio_result_fifo #(
   parameter  int unsigned RES_W      = 24,
   parameter  int unsigned FIFO_DEPTH = 16,
   localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [RES_W-1:0] i_push_data,
   input  logic             i_pop,
   input  logic             i_flush,
   output logic [RES_W-1:0] o_head_c,
   output logic [LVL_W-1:0] o_level,
   output logic             o_empty_c,
   output logic             o_full_c,
   output logic             o_drop_c
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   logic [RES_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic             w_pop_ok;
   logic             w_push_ok;

   assign o_level   = r_level;
   assign o_empty_c = (r_level == '0);
   assign o_full_c  = (r_level == LVL_W'(FIFO_DEPTH));
   assign o_head_c  = r_mem[r_rd_ptr];

   // A pop on a full FIFO frees the slot the same-cycle push lands in.
   assign w_pop_ok  = i_pop & ~o_empty_c & ~i_flush;
   assign w_push_ok = i_push & ~i_flush & (~o_full_c | w_pop_ok);
   assign o_drop_c  = i_push & ~i_flush & o_full_c & ~w_pop_ok;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
         unique case ({w_push_ok, w_pop_ok})
            2'b10:   r_level <= r_level + LVL_W'(1);
            2'b01:   r_level <= r_level - LVL_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Storage needs no reset: the level gates every read.
   always_ff @(posedge i_clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
   end

endmodule

// File: rtl/pio_accel_sequencer.sv
// Toggle-handshake command sequencer bridging NIOS PIO ports to a streaming accelerator.
// Define PIO_ACCEL_SEQ_TIMEOUT_EN to abort PUSH after TIMEOUT_CYC cycles without ready.
module pio_accel_sequencer
   import pio_accel_seq_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned RES_W       = 24,
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic              clk_in_clk,
   input  logic              reset_reset_n,
   input  logic [31:0]       po_export,
   input  logic [31:0]       po2_export,
   output logic [31:0]       pi_export,
   output logic              acc_in_valid,
   input  logic              acc_in_ready,
   output logic [DATA_W-1:0] acc_in_data,
   output logic              acc_start,
   input  logic              acc_busy,
   output logic              acc_soft_rst,
   input  logic              acc_out_valid,
   input  logic [RES_W-1:0]  acc_out_data
);
   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

   state_e            r_state;
   state_e            w_state_nxt;
   logic [31:0]       r_po_q;
   logic [31:0]       r_po2_q;
   logic [OP_W-1:0]   r_op;
   logic [OP_W-1:0]   w_op_nxt;
   logic              r_ack;
   logic              w_ack_nxt;
   logic              r_err;
   logic              w_err_set;
   logic              w_err_clr;
   logic [RES_W-1:0]  r_result;
   logic [RES_W-1:0]  w_result_nxt;
   logic              r_in_valid;
   logic              w_in_valid_nxt;
   logic [DATA_W-1:0] r_in_data;
   logic [DATA_W-1:0] w_in_data_nxt;
   logic              r_start;
   logic              w_start_nxt;
   logic              r_soft_rst;
   logic              w_soft_rst_nxt;
   logic              w_pop;
   logic              w_flush;
   logic              w_fifo_empty;
   logic              w_fifo_full;
   logic              w_fifo_drop;
   logic [LVL_W-1:0]  w_fifo_level;
   logic [RES_W-1:0]  w_fifo_head;
   logic              w_timeout;
   logic              w_unused;

   assign w_unused = ^{r_po_q[PO_OP_LSB-1:0], w_fifo_full, 1'(TIMEOUT_CYC)};

   pio_result_fifo #(
      .RES_W      (RES_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk       (clk_in_clk),
      .i_rst_n     (reset_reset_n),
      .i_push      (acc_out_valid),
      .i_push_data (acc_out_data),
      .i_pop       (w_pop),
      .i_flush     (w_flush),
      .o_head_c    (w_fifo_head),
      .o_level     (w_fifo_level),
      .o_empty_c   (w_fifo_empty),
      .o_full_c    (w_fifo_full),
      .o_drop_c    (w_fifo_drop)
   );

   always_ff @(posedge clk_in_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_po_q  <= '0;
         r_po2_q <= '0;
      end else begin
         r_po_q  <= po_export;
         r_po2_q <= po2_export;
      end
   end

`ifdef PIO_ACCEL_SEQ_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TMO_W-1:0] r_tmo_cnt;

   // Counts EXEC cycles of the current command; cleared on every IDLE->EXEC entry.
   always_ff @(posedge clk_in_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_tmo_cnt <= '0;
      end else if ((r_state == ST_IDLE) && (w_state_nxt == ST_EXEC)) begin
         r_tmo_cnt <= '0;
      end else if ((r_state == ST_EXEC) && !w_timeout) begin
         r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end
   end

   assign w_timeout = (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
   assign w_timeout = 1'b0;
`endif

   // Next-state and next-output decode.
   always_comb begin
      w_state_nxt    = r_state;
      w_op_nxt       = r_op;
      w_ack_nxt      = r_ack;
      w_err_set      = 1'b0;
      w_err_clr      = 1'b0;
      w_result_nxt   = r_result;
      w_in_valid_nxt = r_in_valid;
      w_in_data_nxt  = r_in_data;
      w_start_nxt    = 1'b0;
      w_soft_rst_nxt = 1'b0;
      w_pop          = 1'b0;
      w_flush        = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (r_po_q[PO_REQ_BIT] != r_ack) begin
               w_op_nxt    = r_po_q[PO_OP_LSB +: OP_W];
               w_state_nxt = ST_EXEC;
               if (w_op_nxt == OP_PUSH) begin
                  w_in_valid_nxt = 1'b1;
                  w_in_data_nxt  = r_po2_q[DATA_W-1:0];
               end
            end
         end
         ST_EXEC: begin
            w_state_nxt = ST_ACK;
            w_ack_nxt   = ~r_ack;
            case (r_op)
               OP_NOP: begin
               end
               OP_PUSH: begin
                  if (acc_in_ready) begin
                     w_in_valid_nxt = 1'b0;
                  end else if (w_timeout) begin
                     w_in_valid_nxt = 1'b0;
                     w_err_set      = 1'b1;
                  end else begin
                     w_state_nxt = ST_EXEC;
                     w_ack_nxt   = r_ack;
                  end
               end
               OP_START: begin
                  if (acc_busy) w_err_set   = 1'b1;
                  else          w_start_nxt = 1'b1;
               end
               OP_POP: begin
                  if (w_fifo_empty) begin
                     w_err_set = 1'b1;
                  end else begin
                     w_result_nxt = w_fifo_head;
                     w_pop        = 1'b1;
                  end
               end
               OP_CLR: begin
                  w_err_clr      = 1'b1;
                  w_flush        = 1'b1;
                  w_soft_rst_nxt = 1'b1;
               end
               default: w_err_set = 1'b1;
            endcase
         end
         ST_ACK:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_state    <= ST_IDLE;
         r_op       <= OP_NOP;
         r_ack      <= 1'b0;
         r_err      <= 1'b0;
         r_result   <= '0;
         r_in_valid <= 1'b0;
         r_in_data  <= '0;
         r_start    <= 1'b0;
         r_soft_rst <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_op       <= w_op_nxt;
         r_ack      <= w_ack_nxt;
         r_err      <= w_err_clr ? 1'b0 : (r_err | w_err_set | w_fifo_drop);
         r_result   <= w_result_nxt;
         r_in_valid <= w_in_valid_nxt;
         r_in_data  <= w_in_data_nxt;
         r_start    <= w_start_nxt;
         r_soft_rst <= w_soft_rst_nxt;
      end
   end

   assign acc_in_valid = r_in_valid;
   assign acc_in_data  = r_in_data;
   assign acc_start    = r_start;
   assign acc_soft_rst = r_soft_rst;

   // Status word; busy also reflects the accelerator's own run flag.
   always_comb begin
      pi_export                               = '0;
      pi_export[PI_ACK_BIT]                   = r_ack;
      pi_export[PI_BUSY_BIT]                  = (r_state != ST_IDLE) | acc_busy;
      pi_export[PI_ERR_BIT]                   = r_err;
      pi_export[PI_EMPTY_BIT]                 = w_fifo_empty;
      pi_export[PI_LVL_LSB +: PI_LVL_W]       = sat_level(32'(w_fifo_level));
      pi_export[PI_RES_W-1:0]                 = PI_RES_W'(r_result);
   end

endmodule
